// File: rtl/hilbert_coeff_controller_if.sv
// Host/ADC/transformer-side signal bundle for hilbert_coeff_controller.
// Readback signals exist only when HILBERT_COEFF_READBACK_EN is defined.
interface hilbert_coeff_controller_if #(
  parameter int unsigned NUM_BITS     = 24,
  parameter int unsigned COEFF_LENGTH = 13
);
  localparam int unsigned AW = (COEFF_LENGTH > 1) ? $clog2(COEFF_LENGTH) : 1;

  logic                       tick_i;
  logic                       wr_en_i;
  logic                       wr_sel_i;
  logic [AW-1:0]              wr_addr_i;
  logic signed [NUM_BITS-1:0] wr_data_i;
  logic                       commit_i;
  logic                       filt_done_i;
  logic                       filt_tick_o;
  logic signed [NUM_BITS-1:0] ha_coeffs_o    [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] delay_coeffs_o [COEFF_LENGTH];
  logic                       busy_o;
  logic                       commit_pending_o;
  logic                       commit_ack_o;
  logic                       overrun_o;
  logic                       wr_err_o;
  logic                       timeout_o;
`ifdef HILBERT_COEFF_READBACK_EN
  logic                       rd_sel_i;
  logic [AW-1:0]              rd_addr_i;
  logic signed [NUM_BITS-1:0] rd_data_o;
`endif

  modport slave (
`ifdef HILBERT_COEFF_READBACK_EN
    input  rd_sel_i, input rd_addr_i, output rd_data_o,
`endif
    input  tick_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, commit_i, filt_done_i,
    output filt_tick_o, ha_coeffs_o, delay_coeffs_o, busy_o, commit_pending_o,
           commit_ack_o, overrun_o, wr_err_o, timeout_o
  );

  modport master (
`ifdef HILBERT_COEFF_READBACK_EN
    output rd_sel_i, output rd_addr_i, input rd_data_o,
`endif
    output tick_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, commit_i, filt_done_i,
    input  filt_tick_o, ha_coeffs_o, delay_coeffs_o, busy_o, commit_pending_o,
           commit_ack_o, overrun_o, wr_err_o, timeout_o
  );
endinterface

// File: rtl/hilbert_coeff_controller.sv
// Sample sequencer and double-buffered coefficient manager for the Hilbert FIR pair.
// Define HILBERT_COEFF_READBACK_EN to add registered shadow-bank readback.
module hilbert_coeff_controller #(
  parameter int unsigned NUM_BITS       = 24,
  parameter int unsigned COEFF_LENGTH   = 13,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  hilbert_coeff_controller_if.slave bus
);
  localparam int unsigned AW = (COEFF_LENGTH > 1) ? $clog2(COEFF_LENGTH) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWAP} state_t;

  state_t                     r_state;
  logic signed [NUM_BITS-1:0] r_ha_sh  [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] r_dl_sh  [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] r_ha_act [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] r_dl_act [COEFF_LENGTH];
  logic [CW-1:0]              r_tmo_cnt;
  logic                       r_filt_tick;
  logic                       r_busy;
  logic                       r_pending;
  logic                       r_ack;
  logic                       r_overrun;
  logic                       r_wr_err;
  logic                       r_timeout;

  logic                       w_addr_ok;
  logic                       w_wr_ok;
  logic                       w_commit_req;

  assign w_addr_ok    = (32'(bus.wr_addr_i) < COEFF_LENGTH);
  assign w_wr_ok      = bus.wr_en_i && w_addr_ok;
  // A commit arriving this cycle counts as pending so IDLE reaches SWAP one cycle later.
  assign w_commit_req = r_pending || bus.commit_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_tmo_cnt   <= '0;
      r_filt_tick <= 1'b0;
      r_busy      <= 1'b0;
      r_pending   <= 1'b0;
      r_ack       <= 1'b0;
      r_overrun   <= 1'b0;
      r_wr_err    <= 1'b0;
      r_timeout   <= 1'b0;
      for (int unsigned i = 0; i < COEFF_LENGTH; i++) begin
        r_ha_sh[i]  <= '0;
        r_dl_sh[i]  <= '0;
        r_ha_act[i] <= '0;
        r_dl_act[i] <= '0;
      end
    end else begin
      r_filt_tick <= 1'b0;
      r_ack       <= 1'b0;
      r_overrun   <= 1'b0;
      r_wr_err    <= bus.wr_en_i && !w_addr_ok;

      if (w_wr_ok) begin
        if (bus.wr_sel_i) r_dl_sh[bus.wr_addr_i] <= bus.wr_data_i;
        else              r_ha_sh[bus.wr_addr_i] <= bus.wr_data_i;
      end

      if (bus.commit_i) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.tick_i) begin
            r_filt_tick <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
          end else if (w_commit_req) begin
            r_state <= S_SWAP;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_tmo_cnt <= r_tmo_cnt + CW'(1);
          if (bus.tick_i) r_overrun <= 1'b1;
          if (bus.filt_done_i) begin
            r_state <= w_commit_req ? S_SWAP : S_IDLE;
            r_busy  <= w_commit_req;
          end else if (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end
        end
        S_SWAP: begin
          // Nonblocking copy sees the shadow value from before any same-cycle write.
          for (int unsigned i = 0; i < COEFF_LENGTH; i++) begin
            r_ha_act[i] <= r_ha_sh[i];
            r_dl_act[i] <= r_dl_sh[i];
          end
          r_pending <= bus.commit_i;
          r_ack     <= 1'b1;
          if (bus.tick_i) begin
            r_filt_tick <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.filt_tick_o      = r_filt_tick;
  assign bus.ha_coeffs_o      = r_ha_act;
  assign bus.delay_coeffs_o   = r_dl_act;
  assign bus.busy_o           = r_busy;
  assign bus.commit_pending_o = r_pending;
  assign bus.commit_ack_o     = r_ack;
  assign bus.overrun_o        = r_overrun;
  assign bus.wr_err_o         = r_wr_err;
  assign bus.timeout_o        = r_timeout;

`ifdef HILBERT_COEFF_READBACK_EN
  logic signed [NUM_BITS-1:0] r_rd_data;
  logic                       w_rd_ok;

  assign w_rd_ok = (32'(bus.rd_addr_i) < COEFF_LENGTH);

  always_ff @(posedge clk_i) begin
    if (reset_i)      r_rd_data <= '0;
    else if (w_rd_ok) r_rd_data <= bus.rd_sel_i ? r_dl_sh[bus.rd_addr_i] : r_ha_sh[bus.rd_addr_i];
    else              r_rd_data <= '0;
  end

  assign bus.rd_data_o = r_rd_data;
`endif
endmodule

// File: doc/hilbert_coeff_controller.md
# hilbert_coeff_controller

Sequencer and coefficient manager for the Hilbert transformer pair (the cos FIR and the sin delay-line FIR).
- Forwards the sample tick to the datapath and waits for the datapath's done.
- Holds active and shadow coefficient banks for both FIRs.
- Lets a host rewrite coefficients at any time.
- Applies a commit atomically only while the FIRs are idle, so a filtered sample is never computed with mixed coefficient sets.
- Sits between the ADC sample strobe/host register interface and the transformer's `tick_i`, `ha_coeffs`, `delay_coeffs` and `done_o`.

## Interface
Parameters:
- `NUM_BITS`, 24, coefficient width (signed).
- `COEFF_LENGTH`, 13, taps per FIR.
- `TIMEOUT_CYCLES`, 64, maximum RUN cycles to wait for done.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  sample strobe, single-cycle pulse.
- `wr_en_i`  in  1  shadow write strobe.
- `wr_sel_i`  in  1  bank select: 0 = ha, 1 = delay.
- `wr_addr_i`  in  `$clog2(COEFF_LENGTH)`  tap index.
- `wr_data_i`  in  `NUM_BITS` signed  coefficient value.
- `commit_i`  in  1  request shadow→active copy.
- `filt_done_i`  in  1  done pulse from the transformer.
- `filt_tick_o`  out  1  tick to the transformer.
- `ha_coeffs_o[COEFF_LENGTH]`  out  `NUM_BITS` signed each  active ha bank.
- `delay_coeffs_o[COEFF_LENGTH]`  out  `NUM_BITS` signed each  active delay bank.
- `busy_o`  out  1  high in RUN or SWAP.
- `commit_pending_o`  out  1  commit accepted, not yet applied.
- `commit_ack_o`  out  1  one-cycle pulse, high in the first cycle new coefficients are visible.
- `overrun_o`  out  1  one-cycle pulse, tick dropped.
- `wr_err_o`  out  1  one-cycle pulse, write address ≥ `COEFF_LENGTH`.
- `timeout_o`  out  1  sticky; cleared only by reset.

## Operation
FSM states:
- **IDLE**
  - `tick_i` → assert `filt_tick_o` next cycle, go to RUN.
  - Else, if commit pending → go to SWAP.
  - `tick_i` wins over a pending commit.
- **RUN**
  - Wait for `filt_done_i`.
  - On done → go to SWAP if commit pending, else IDLE.
  - Timeout counter is cleared on RUN entry and increments each RUN cycle. At `TIMEOUT_CYCLES-1` with no done → set `timeout_o`, go to IDLE (pending commit waits in IDLE).
  - Done in the same cycle as the timeout beats the timeout.
  - `tick_i` in RUN → dropped, `overrun_o` pulses next cycle.
- **SWAP** (exactly one cycle)
  - Both active banks ← shadow banks.
  - `commit_pending_o` clears.
  - `commit_ack_o` pulses next cycle.
  - Next state: IDLE, or RUN if a tick was latched.
  - `tick_i` in SWAP is latched (one-deep) and forwarded as `filt_tick_o` in the cycle after SWAP.

Shadow writes:
- Accepted in any state.
- An out-of-range address → no write, `wr_err_o` pulse.
- A write in the SWAP cycle: the copy uses the pre-write shadow value; the write lands in shadow only.

Commit handling:
- `commit_i` while already pending → no additional effect.
- `commit_i` in the SWAP cycle → starts a new pending commit.

Reset values:
- Active and shadow banks: all zero.
- Every output: 0.
- FSM: IDLE.
- Tick latch and timeout counter: cleared.
- Reset mid-RUN or mid-SWAP abandons the operation; no ack is issued.

## Timing
- `tick_i` in IDLE at cycle N → `filt_tick_o` high at N+1 only; `busy_o` high from N+1.
- `filt_done_i` at M with no commit → IDLE at M+1, `busy_o` low at M+1.
- `filt_done_i` at M with commit pending → SWAP at M+1, new coefficients and `commit_ack_o` at M+2.
- `commit_i` in IDLE at C → SWAP at C+1, ack and new coefficients at C+2.
- `commit_pending_o` is high from C+1 until the SWAP cycle inclusive.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `HILBERT_COEFF_READBACK_EN` defined adds readback ports:
  - `rd_sel_i` (1).
  - `rd_addr_i` (`$clog2(COEFF_LENGTH)`).
  - `rd_data_o` (`NUM_BITS`): the shadow value, registered with 1-cycle latency.
  - Out-of-range `rd_addr_i` reads 0.
- Without the macro, these ports and their logic do not exist.

## Test plan
- Reset, then `tick_i` at cycle 10 → `filt_tick_o` at 11 only; `filt_done_i` at 20 → `busy_o` low at 21.
- Write ha[6] = 24'h200000 and delay[6] = 24'h400000, then `commit_i` in IDLE at C → outputs unchanged until C+2; at C+2 they update and `commit_ack_o` is a single pulse.
- `commit_i` during RUN → no output change until done at M; SWAP at M+1, ack and new values at M+2.
- `tick_i` during RUN → `overrun_o` pulse and no `filt_tick_o`; `tick_i` during SWAP → `filt_tick_o` in the cycle after SWAP.
- Withhold `filt_done_i` → `timeout_o` set after 64 RUN cycles; FSM in IDLE; the next tick is forwarded normally.
- Write to `wr_addr_i` = 13 → `wr_err_o` pulse, shadow unchanged; a write in the SWAP cycle leaves the active value at its old shadow value.
